// File: rtl/strobe_mem_pkg.sv
// Shared definitions for the strobed memory bank: FSM state encoding and
// the parameter legality helpers used at elaboration time.
package strobe_mem_pkg;

  // Clear sweep in progress, or normal read/write service.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Only one- and two-stage read pipelines are supported.
  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Byte lanes must tile the data word exactly.
  function automatic bit data_w_ok(input int data_w);
    return (data_w > 0) && ((data_w % 8) == 0);
  endfunction

endpackage

// File: rtl/strobe_mem_bank_if.sv
// Bus bundle for the strobed memory bank: clear control, port A
// (strobed read/write) and port B (full-word write).
interface strobe_mem_bank_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              clr_req;
  logic              busy;
  logic              a_en;
  logic [ADDR_W-1:0] a_addr;
  logic              a_wen;
  logic [STRB_W-1:0] a_wstrb;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ren;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  logic              b_wen;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;

  modport master (
    output clr_req, a_en, a_addr, a_wen, a_wstrb, a_wdata, a_ren,
           b_wen, b_addr, b_wdata,
    input  busy, a_rdata, a_rvalid
  );

  modport slave (
    input  clr_req, a_en, a_addr, a_wen, a_wstrb, a_wdata, a_ren,
           b_wen, b_addr, b_wdata,
    output busy, a_rdata, a_rvalid
  );
endinterface

// File: rtl/strobe_mem_array.sv
// Storage array with three write sources (clear sweep, strobed port A,
// full-word port B) and an asynchronous read port. The read value is the
// pre-write contents, since all array updates are non-blocking.
module strobe_mem_array #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              clr_we,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [DATA_W-1:0] clr_data,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [STRB_W-1:0] a_wstrb,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] base_s;
  logic [DATA_W-1:0] merged_s;

  // Build the port A word: strobed bytes from A, the rest from B when B
  // hits the same word this cycle, otherwise from the current contents.
  always_comb begin
    base_s   = mem_r[a_addr];
    merged_s = mem_r[a_addr];
    if (b_we && (b_addr == a_addr)) begin
      base_s = b_wdata;
    end else begin
      base_s = mem_r[a_addr];
    end
    for (int i = 0; i < STRB_W; i++) begin
      if (a_wstrb[i]) begin
        merged_s[8*i +: 8] = a_wdata[8*i +: 8];
      end else begin
        merged_s[8*i +: 8] = base_s[8*i +: 8];
      end
    end
  end

  // Array update: the sweep owns the array while it runs; otherwise B then A,
  // so a same-address A write (already merged with B) lands last.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_r[clr_addr] <= clr_data;
    end else begin
      if (b_we) begin
        mem_r[b_addr] <= b_wdata;
      end
      if (a_we) begin
        mem_r[a_addr] <= merged_s;
      end
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/strobe_mem_bank.sv
// Two-port strobed memory bank with a self-initialising clear sweep.
// The top holds the CLEAR/READY FSM, request gating and the read pipeline;
// storage and byte merging live in strobe_mem_array.
module strobe_mem_bank
  import strobe_mem_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 12,
  parameter logic [DATA_W-1:0] INIT_WORD = {DATA_W{1'b0}},
  parameter int                RD_LAT    = 1
) (
  input  logic           clk,
  input  logic           rst,
  strobe_mem_bank_if.slave bus
);
  localparam int                STRB_W    = DATA_W / 8;
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  if (!data_w_ok(DATA_W) || !rd_lat_ok(RD_LAT)) begin : g_param_err
    $error("strobe_mem_bank: DATA_W must be a multiple of 8 and RD_LAT must be 1 or 2");
  end

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;
  logic              busy_r;

  logic              ready_s;
  logic              clr_we_s;
  logic              a_we_s;
  logic              b_we_s;
  logic              rd_issue_s;
  logic [DATA_W-1:0] rd_data_s;

  logic              vld_r [RD_LAT];
  logic [DATA_W-1:0] dat_r [RD_LAT];

  // Next-state logic: sweep one word per cycle, stop after the last address
  // by explicit compare; a clear request is honoured only from READY.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = ZERO_ADDR;
        end else begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = cnt_r + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (bus.clr_req) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = ZERO_ADDR;
        end else begin
          state_nxt_s = ST_READY;
          cnt_nxt_s   = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = ZERO_ADDR;
      end
    endcase
  end

  // State register, sweep counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_CLEAR;
      cnt_r   <= ZERO_ADDR;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
    end
  end

  // Requests are accepted only in READY; anything arriving during the
  // sweep (or during reset) is dropped at issue time.
  assign ready_s    = (state_r == ST_READY) && !rst;
  assign clr_we_s   = (state_r == ST_CLEAR);
  assign a_we_s     = ready_s && bus.a_en && bus.a_wen;
  assign b_we_s     = ready_s && bus.b_wen;
  assign rd_issue_s = ready_s && bus.a_en && bus.a_ren;

  strobe_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .STRB_W (STRB_W)
  ) u_array (
    .clk      (clk),
    .clr_we   (clr_we_s),
    .clr_addr (cnt_r),
    .clr_data (INIT_WORD),
    .a_we     (a_we_s),
    .a_addr   (bus.a_addr),
    .a_wstrb  (bus.a_wstrb),
    .a_wdata  (bus.a_wdata),
    .b_we     (b_we_s),
    .b_addr   (bus.b_addr),
    .b_wdata  (bus.b_wdata),
    .rd_addr  (bus.a_addr),
    .rd_data  (rd_data_s)
  );

  // Read pipeline: stage 0 captures the pre-write word at issue; later
  // stages shift it along. Data registers only load with a valid token so
  // the last stage holds its value between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_r[i] <= 1'b0;
        dat_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      vld_r[0] <= rd_issue_s;
      if (rd_issue_s) begin
        dat_r[0] <= rd_data_s;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.a_rvalid = vld_r[RD_LAT-1];
  assign bus.a_rdata  = dat_r[RD_LAT-1];

endmodule

// File: tb/tb_strobe_mem_bank.sv
// Directed bench for strobe_mem_bank (DATA_W=64, ADDR_W=4, RD_LAT=2).
// Reads push their hand-computed result into a queue; a monitor pops and
// compares whenever a_rvalid is seen.
module tb_strobe_mem_bank;
  localparam int          DW   = 64;
  localparam int          AW   = 4;
  localparam logic [63:0] INIT = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;
  logic [63:0] exp_q [$];

  strobe_mem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  strobe_mem_bank #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .INIT_WORD (INIT),
    .RD_LAT    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.clr_req = 1'b0;
    bus.a_en    = 1'b0;
    bus.a_addr  = 4'h0;
    bus.a_wen   = 1'b0;
    bus.a_wstrb = 8'h00;
    bus.a_wdata = 64'h0;
    bus.a_ren   = 1'b0;
    bus.b_wen   = 1'b0;
    bus.b_addr  = 4'h0;
    bus.b_wdata = 64'h0;
  endtask

  task automatic nop(input int n);
    repeat (n) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [7:0] strb, input logic [63:0] data);
    @(negedge clk);
    idle();
    bus.a_en = 1'b1; bus.a_wen = 1'b1; bus.a_addr = addr;
    bus.a_wstrb = strb; bus.a_wdata = data;
  endtask

  task automatic b_write(input logic [3:0] addr, input logic [63:0] data);
    @(negedge clk);
    idle();
    bus.b_wen = 1'b1; bus.b_addr = addr; bus.b_wdata = data;
  endtask

  // expect_rd=0 is used while busy: the request must be dropped.
  task automatic a_read(input logic [3:0] addr, input logic [63:0] exp, input bit expect_rd);
    @(negedge clk);
    idle();
    bus.a_en = 1'b1; bus.a_ren = 1'b1; bus.a_addr = addr;
    if (expect_rd) exp_q.push_back(exp);
  endtask

  // Called on a negedge: counts negedges with busy high until it drops.
  task automatic wait_clear(input string name, input int exp_cycles);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check(name, 64'(cnt), 64'(exp_cycles));
  endtask

  // Monitor: every a_rvalid must match the oldest outstanding read.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.a_rvalid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got a_rvalid=1 (rdata %h), expected no pending read", bus.a_rdata);
        end else begin
          check("rdata", bus.a_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(bus.busy),     64'd1);
    check("rst_rvalid", 64'(bus.a_rvalid), 64'd0);
    check("rst_rdata",  bus.a_rdata,       64'h0);
    rst = 1'b0;
    wait_clear("busy_after_rst", 16);

    // Whole array initialised; back-to-back reads.
    for (int a = 0; a < 16; a++) a_read(4'(a), INIT, 1'b1);
    nop(3);

    // Strobed low half, strobed top byte, zero strobe.
    a_write(4'd3, 8'h0F, 64'h1111_2222_3333_4444);
    a_write(4'd12, 8'h80, 64'hCC00_0000_0000_0000);
    a_write(4'd10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    b_write(4'd9, 64'h0F0F_0F0F_F0F0_F0F0);
    a_read(4'd3,  64'hA5A5_A5A5_3333_4444, 1'b1);
    a_read(4'd12, 64'hCCA5_A5A5_A5A5_A5A5, 1'b1);
    a_read(4'd10, INIT, 1'b1);
    a_read(4'd9,  64'h0F0F_0F0F_F0F0_F0F0, 1'b1);

    // Same-cycle A and B to one address: strobed A byte wins.
    a_write(4'd5, 8'h01, 64'h0000_0000_0000_00FF);
    bus.b_wen = 1'b1; bus.b_addr = 4'd5; bus.b_wdata = 64'h0123_4567_89AB_CDEF;
    a_read(4'd5, 64'h0123_4567_89AB_CDFF, 1'b1);
    nop(4);

    // Read and write addr 7 together: old value two cycles later, then new.
    a_write(4'd7, 8'hFF, 64'hDEAD_BEEF_0000_7777);
    bus.a_ren = 1'b1;
    exp_q.push_back(INIT);
    nop(1);
    check("lat_cycle1_rvalid", 64'(bus.a_rvalid), 64'd0);
    @(negedge clk);
    check("lat_cycle2_rvalid", 64'(bus.a_rvalid), 64'd1);
    a_read(4'd7, 64'hDEAD_BEEF_0000_7777, 1'b1);
    nop(4);

    // Clear requested alongside an in-flight read; traffic during busy dropped.
    a_read(4'd3, 64'hA5A5_A5A5_3333_4444, 1'b1);
    bus.clr_req = 1'b1;
    fork
      begin
        @(negedge clk);
        wait_clear("busy_after_clr_req", 16);
      end
      begin
        a_write(4'd1, 8'hFF, 64'h1234_5678_1234_5678);
        bus.clr_req = 1'b1;
        b_write(4'd2, 64'h5555_6666_7777_8888);
        a_read(4'd4, INIT, 1'b0);
        a_write(4'd15, 8'hFF, 64'h0);
        bus.b_wen = 1'b1; bus.b_addr = 4'd14; bus.b_wdata = 64'h0;
        nop(1);
      end
    join
    for (int a = 0; a < 16; a++) a_read(4'(a), INIT, 1'b1);
    nop(4);

    // Reset while the sweep is at address 9 restarts it from 0.
    a_write(4'd6, 8'hFF, 64'h6666_6666_6666_6666);
    @(negedge clk);
    idle();
    bus.clr_req = 1'b1;
    nop(10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("busy_after_mid_rst", 16);
    a_read(4'd0,  INIT, 1'b1);
    a_read(4'd6,  INIT, 1'b1);
    a_read(4'd15, INIT, 1'b1);
    nop(6);

    check("pending_reads", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_mem_bank.md
STROBE_MEM_BANK -- requirements
Module: strobe_mem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 64, word width in bits, multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 12, word address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter INIT_WORD, default 0, DATA_W-bit value written to every word by the clear sequence.
REQ-004 SHALL have parameter RD_LAT, default 1, read latency in cycles, legal values 1 or 2.
REQ-005 SHALL define the derived constant STRB_W = DATA_W/8.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 clr_req  input  1  one-cycle request to rerun the clear sequence.
REQ-009 busy  output  1  high while the clear sequence runs.
REQ-010 a_en  input  1  port A enable.
REQ-011 a_addr  input  ADDR_W  port A word address.
REQ-012 a_wen  input  1  port A write enable.
REQ-013 a_wstrb  input  STRB_W  port A byte strobes, bit i covers bits [8i+7:8i].
REQ-014 a_wdata  input  DATA_W  port A write data.
REQ-015 a_ren  input  1  port A read enable.
REQ-016 a_rdata  output  DATA_W  port A read data.
REQ-017 a_rvalid  output  1  one-cycle pulse qualifying a_rdata.
REQ-018 b_wen  input  1  port B full-word write enable (independent of a_en).
REQ-019 b_addr  input  ADDR_W  port B write address.
REQ-020 b_wdata  input  DATA_W  port B write data.

Function
REQ-021 FSM states SHALL be CLEAR and READY; reset enters CLEAR with sweep counter 0.
REQ-022 In CLEAR, one word per cycle SHALL be written with INIT_WORD at the counter address; after address DEPTH-1, next state SHALL be READY (DEPTH cycles total).
REQ-023 busy SHALL be 1 exactly while in CLEAR.
REQ-024 clr_req in READY SHALL enter CLEAR with counter 0 on the next cycle; clr_req in CLEAR SHALL be ignored (no restart).
REQ-025 While busy, all port A and port B requests SHALL be dropped: no write, no a_rvalid.
REQ-026 Port A write in READY: when a_en & a_wen, each byte with a_wstrb[i]=1 SHALL take a_wdata byte i; other bytes unchanged.
REQ-027 Port B write in READY: when b_wen, the whole word at b_addr SHALL take b_wdata.
REQ-028 A and B writes to the same address in one cycle: strobed A bytes SHALL win; unstrobed bytes SHALL take b_wdata.
REQ-029 Port A read: when a_en & a_ren in READY, a_rdata SHALL present the word as it was before that cycle's writes (read-old), valid RD_LAT cycles later with a_rvalid=1 for that one cycle.
REQ-030 Back-to-back reads SHALL sustain one result per cycle; the pipeline SHALL be fully pipelined, no stalls.
REQ-031 a_rdata SHALL hold its last value when a_rvalid=0.
REQ-032 A clear starting while reads are in flight SHALL still deliver those reads; issue gating applies only at request time.
REQ-033 Address arithmetic SHALL be exactly ADDR_W bits; counter terminal detection SHALL not rely on wrap to 0.

Reset
REQ-034 rst SHALL set state CLEAR, counter 0, busy 1, a_rvalid 0, a_rdata 0, and flush the read pipeline.
REQ-035 rst asserted mid-clear SHALL restart the sweep at address 0.
REQ-036 Array contents SHALL not be reset directly; the clear sequence SHALL initialise them.

Structure
REQ-037 FSM state enum and the RD_LAT legality check SHALL live in shared package strobe_mem_pkg.
REQ-038 The storage array with byte-merge write logic SHALL be sub-module strobe_mem_array; FSM, arbitration and read pipeline SHALL live in the top.
REQ-039 An elaboration-time error SHALL fire if DATA_W%8 != 0 or RD_LAT not in {1,2}.

Verification (DATA_W=64, ADDR_W=4, INIT_WORD=64'hA5A5_A5A5_A5A5_A5A5)
REQ-040 Release rst -> busy high exactly 16 cycles; reads of all addresses after READY return 64'hA5A5_A5A5_A5A5_A5A5.
REQ-041 A write addr 3, wstrb 8'h0F, wdata 64'h1111_2222_3333_4444 -> read addr 3 returns 64'hA5A5_A5A5_3333_4444.
REQ-042 Same cycle: A addr 5 wstrb 8'h01 data 64'hFF, B addr 5 data 64'h0123_4567_89AB_CDEF -> addr 5 reads 64'h0123_4567_89AB_CDFF.
REQ-043 Read and write addr 7 in one cycle with RD_LAT=2 -> a_rvalid two cycles later with old value; next read returns new value.
REQ-044 clr_req after writes, plus writes issued during busy -> all words read INIT_WORD afterwards, no a_rvalid during busy.
REQ-045 rst asserted at counter 9 -> sweep restarts at 0, busy lasts 16 more cycles.
